// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and size decode for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    FIN,
    RESP
  } state_t;

  // Byte mask for the access size encoded in funct3[1:0] (1, 2 or 4 bytes).
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Unsigned loads have no store counterpart; 011/110/111 are never legal.
  function automatic logic f3_valid(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: f3_valid = 1'b1;
      F3_BU, F3_HU:     f3_valid = ~we;
      default:          f3_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, response and data-memory signal bundle of the load/store unit
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Execute stage plus data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shifting, byte enables and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data,
  output logic        split
);

  logic [7:0]  mask8;
  logic [4:0]  sh;
  logic [31:0] raw;

  // Lanes of an access spanning two words: low nibble/bytes go to lo, the spill to hi.
  always_comb begin
    mask8     = {4'b0000, size_mask(funct3[1:0])} << off;
    be_lo     = mask8[3:0];
    be_hi     = mask8[7:4];
    sh        = {off, 3'b000};
    wdata_lo  = wdata << sh;
    wdata_hi  = (off == 2'd0) ? 32'd0 : (wdata >> (6'd32 - {1'b0, sh}));
    raw       = 32'({hi_word, lo_word} >> sh);
    split     = ((funct3[1:0] == 2'b01) && (off == 2'd3)) ||
                ((funct3[1:0] == 2'b10) && (off != 2'd0));
    case (funct3[1:0])
      2'b00:   load_data = funct3[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   load_data = funct3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM splitting misaligned accesses into two word accesses
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q, lo_q, hi_q, rdata_q;
  logic                  err_q;
  logic [ADDR_WIDTH-3:0] lo_w, hi_w;
  logic [DATA_WIDTH-1:0] lo_word, hi_word, wdata_lo, wdata_hi, load_data;
  logic [3:0]            be_lo, be_hi;
  logic                  split;

  assign lo_w = addr_q[ADDR_WIDTH-1:2];
  assign hi_w = lo_w + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  // Read data is only valid in the cycle after the read, so the final word bypasses its register.
  assign lo_word = (state == HI)  ? bus.mem_rdata : lo_q;
  assign hi_word = (state == FIN) ? bus.mem_rdata : hi_q;

  lsu_align u_align (
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .lo_word   (lo_word),
    .hi_word   (hi_word),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data),
    .split     (split)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and memory-side outputs, decoded only from state and latched request.
  always_comb begin
    state_next    = state;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (bus.req_valid) state_next = f3_valid(bus.req_funct3, bus.req_we) ? LO : RESP;
      LO: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = lo_w;
        if (we_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_be    = be_lo;
          bus.mem_wdata = wdata_lo;
          state_next    = split ? HI : RESP;
        end else begin
          state_next = HI;
        end
      end
      HI: begin
        if (we_q) begin
          bus.mem_en    = 1'b1;
          bus.mem_addr  = hi_w;
          bus.mem_we    = 1'b1;
          bus.mem_be    = be_hi;
          bus.mem_wdata = wdata_hi;
          state_next    = RESP;
        end else if (split) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = hi_w;
          state_next   = FIN;
        end else begin
          state_next = RESP;
        end
      end
      FIN:  state_next = RESP;
      RESP: if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      addr_q  <= bus.req_addr;
      f3_q    <= bus.req_funct3;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
    end
  end

  // Capture the low and high read words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (state == HI && !we_q) lo_q <= bus.mem_rdata;
      if (state == FIN)         hi_q <= bus.mem_rdata;
    end
  end

  // Registered response: error flag at acceptance, formatted load data on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      err_q   <= ~f3_valid(bus.req_funct3, bus.req_we);
      rdata_q <= '0;
    end else if (!we_q && ((state == HI && state_next == RESP) || state == FIN)) begin
      rdata_q <= load_data;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [0:4095];

  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-read data memory with byte-lane writes.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      mem[12'h400]  <= 32'h80FFFF7F;
      mem[12'h401]  <= 32'hDDCCBBAA;
      mem[12'h402]  <= 32'h44332211;
      bus.mem_rdata <= 32'd0;
    end else if (bus.mem_en) begin
      if (!bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[11:0]];
      else
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[11:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns one step after acceptance (cycle T+1).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("ready_before_issue", 32'(bus.req_ready), 32'd1);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid  = 1'b0;
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("resp_cleared", 32'(bus.resp_valid), 32'd0);
    chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input int lat, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'd0);
    repeat (lat - 2) step();
    chk({tag, "_early"}, 32'(bus.resp_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    take_resp();
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Byte loads from word 0x400 = 0x80FFFF7F.
    issue(1'b0, F3_B, 32'h1003, 32'd0);
    chk("lb_mem_en", 32'(bus.mem_en), 32'd1);
    chk("lb_mem_we", 32'(bus.mem_we), 32'd0);
    chk("lb_mem_addr", 32'(bus.mem_addr), 32'h400);
    chk("lb_mem_be", 32'(bus.mem_be), 32'd0);
    step();
    chk("lb_t2_valid", 32'(bus.resp_valid), 32'd0);
    step();
    chk("lb_t3_valid", 32'(bus.resp_valid), 32'd1);
    chk("lb_rdata", bus.resp_rdata, 32'hFFFFFF80);
    take_resp();
    load_check("lbu_1003", F3_BU, 32'h1003, 3, 32'h00000080);
    load_check("lb_1000", F3_B, 32'h1000, 3, 32'h0000007F);

    // Aligned byte store.
    issue(1'b1, F3_B, 32'h1002, 32'h000000A5);
    chk("sb_mem_en", 32'(bus.mem_en), 32'd1);
    chk("sb_mem_we", 32'(bus.mem_we), 32'd1);
    chk("sb_mem_addr", 32'(bus.mem_addr), 32'h400);
    chk("sb_mem_be", 32'(bus.mem_be), 32'b0100);
    chk("sb_mem_wdata", bus.mem_wdata, 32'h00A50000);
    chk("sb_t1_valid", 32'(bus.resp_valid), 32'd0);
    step();
    chk("sb_t2_valid", 32'(bus.resp_valid), 32'd1);
    chk("sb_err", 32'(bus.resp_err), 32'd0);
    chk("sb_rdata", bus.resp_rdata, 32'd0);
    chk("sb_t2_mem_en", 32'(bus.mem_en), 32'd0);
    take_resp();
    load_check("lw_after_sb", F3_W, 32'h1000, 3, 32'h80A5FF7F);

    // Split word store across words 0 and 1.
    issue(1'b1, F3_W, 32'h0003, 32'h11223344);
    chk("sw_lo_addr", 32'(bus.mem_addr), 32'h0);
    chk("sw_lo_be", 32'(bus.mem_be), 32'b1000);
    chk("sw_lo_wdata", bus.mem_wdata, 32'h44000000);
    chk("sw_lo_we", 32'(bus.mem_we), 32'd1);
    step();
    chk("sw_hi_addr", 32'(bus.mem_addr), 32'h1);
    chk("sw_hi_be", 32'(bus.mem_be), 32'b0111);
    chk("sw_hi_wdata", bus.mem_wdata, 32'h00112233);
    chk("sw_hi_en", 32'(bus.mem_en), 32'd1);
    chk("sw_t2_valid", 32'(bus.resp_valid), 32'd0);
    step();
    chk("sw_t3_valid", 32'(bus.resp_valid), 32'd1);
    chk("sw_rdata", bus.resp_rdata, 32'd0);
    take_resp();
    load_check("lw_word0", F3_W, 32'h0000, 3, 32'h44000000);
    load_check("lw_word1", F3_W, 32'h0004, 3, 32'h00112233);

    // Split word load across 0x401/0x402.
    issue(1'b0, F3_W, 32'h1006, 32'd0);
    chk("lws_lo_en", 32'(bus.mem_en), 32'd1);
    chk("lws_lo_addr", 32'(bus.mem_addr), 32'h401);
    step();
    chk("lws_hi_en", 32'(bus.mem_en), 32'd1);
    chk("lws_hi_addr", 32'(bus.mem_addr), 32'h402);
    chk("lws_hi_we", 32'(bus.mem_we), 32'd0);
    step();
    chk("lws_t3_valid", 32'(bus.resp_valid), 32'd0);
    chk("lws_t3_en", 32'(bus.mem_en), 32'd0);
    step();
    chk("lws_t4_valid", 32'(bus.resp_valid), 32'd1);
    chk("lws_rdata", bus.resp_rdata, 32'h2211DDCC);
    take_resp();

    // Halfwords: split at offset 3, unsplit at offset 2.
    load_check("lh_1003", F3_H, 32'h1003, 4, 32'hFFFFAA80);
    load_check("lhu_1003", F3_HU, 32'h1003, 4, 32'h0000AA80);
    load_check("lh_1002", F3_H, 32'h1002, 3, 32'hFFFF80A5);

    // Invalid load funct3 with a stalled consumer and an ignored request.
    issue(1'b0, 3'b011, 32'h1000, 32'd0);
    chk("err_valid", 32'(bus.resp_valid), 32'd1);
    chk("err_flag", 32'(bus.resp_err), 32'd1);
    chk("err_rdata", bus.resp_rdata, 32'd0);
    chk("err_mem_en", 32'(bus.mem_en), 32'd0);
    chk("err_ready", 32'(bus.req_ready), 32'd0);
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h1000;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("err_hold_flag", 32'(bus.resp_err), 32'd1);
      chk("err_hold_rdata", bus.resp_rdata, 32'd0);
      chk("err_hold_mem_en", 32'(bus.mem_en), 32'd0);
      chk("err_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    take_resp();
    step();
    chk("ignored_req_mem_en", 32'(bus.mem_en), 32'd0);

    // Unsigned store is invalid.
    issue(1'b1, F3_BU, 32'h1000, 32'hFF);
    chk("sbu_err_valid", 32'(bus.resp_valid), 32'd1);
    chk("sbu_err_flag", 32'(bus.resp_err), 32'd1);
    chk("sbu_mem_en", 32'(bus.mem_en), 32'd0);
    take_resp();

    // Hi word index wraps to zero.
    issue(1'b0, F3_W, 32'hFFFFFFFD, 32'd0);
    chk("wrap_lo_addr", 32'(bus.mem_addr), 32'h3FFFFFFF);
    step();
    chk("wrap_hi_addr", 32'(bus.mem_addr), 32'h0);
    step();
    step();
    chk("wrap_valid", 32'(bus.resp_valid), 32'd1);
    take_resp();

    // Reset in the middle of a split load.
    issue(1'b0, F3_W, 32'h1006, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_rdata", bus.resp_rdata, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("postrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
